// File: rtl/hazard_issue_unit.sv
// Fetch/issue stage: one instruction per cycle to decode.
// Bubbles are inserted at run time for RAW hazards against recently issued
// writers and for the shadow that follows every branch. A taken branch is
// redirected from execute in the last shadow cycle.
module hazard_issue_unit #(
    parameter int PC_W      = 8,
    parameter int RAW_WIN   = 3,
    parameter int BR_SHADOW = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_in,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [15:0]      imem_data,
    input  logic             br_resolve,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    output logic [15:0]      id_inst,
    output logic             id_valid,
    output logic [PC_W-1:0]  id_pc,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Shadow counter width; at least one bit even when BR_SHADOW is 0.
    localparam int SH_W = ($clog2(BR_SHADOW + 1) > 0) ? $clog2(BR_SHADOW + 1) : 1;

    logic [PC_W-1:0]             pc;
    logic [SH_W-1:0]             shadow;
    logic [RAW_WIN-1:0]          sb_vld;
    logic [RAW_WIN-1:0][2:0]     sb_rd;

    logic [2:0] op;
    logic       wr_en;
    logic [2:0] wr_rd;
    logic       rd_a_en;
    logic       rd_b_en;
    logic [2:0] rd_a;
    logic [2:0] rd_b;
    logic       hazard;
    logic       in_shadow;
    logic       issue;
    logic       is_branch;

    assign imem_addr = pc;
    assign op        = imem_data[15:13];
    assign in_shadow = (shadow != '0);
    assign issue     = !in_shadow && !hazard;
    assign is_branch = (op == 3'b100);

    // Decode write/read register fields of the fetched instruction.
    always_comb begin
        wr_en   = 1'b0;
        wr_rd   = imem_data[2:0];
        rd_a_en = 1'b0;
        rd_b_en = 1'b0;
        rd_a    = imem_data[2:0];
        rd_b    = imem_data[5:3];
        if (imem_data != 16'h0000) begin
            case (op)
                3'b000: begin
                    wr_en   = 1'b1;
                    wr_rd   = imem_data[8:6];
                    rd_a_en = 1'b1;
                    rd_b_en = 1'b1;
                end
                3'b001, 3'b010: begin
                    wr_en   = 1'b1;
                    wr_rd   = imem_data[2:0];
                    rd_b_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // RAW hazard: any live writer in the history matches a source field.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < RAW_WIN; i++) begin
            if (sb_vld[i] && ((rd_a_en && sb_rd[i] == rd_a) ||
                              (rd_b_en && sb_rd[i] == rd_b)))
                hazard = 1'b1;
        end
    end

    // Writer history ages every unstalled cycle; bubbles enter as invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_vld <= '0;
            sb_rd  <= '0;
        end else if (!stall_in) begin
            sb_vld[0] <= issue && wr_en;
            sb_rd[0]  <= wr_rd;
            for (int i = 1; i < RAW_WIN; i++) begin
                sb_vld[i] <= sb_vld[i-1];
                sb_rd[i]  <= sb_rd[i-1];
            end
        end
    end

    // PC and branch shadow; redirect is only honoured in the last shadow cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            shadow <= '0;
        end else if (!stall_in) begin
            if (in_shadow) begin
                shadow <= shadow - 1'b1;
                if (shadow == SH_W'(1) && br_resolve && br_taken)
                    pc <= br_target;
            end else if (!hazard) begin
                pc <= pc + PC_W'(1);
                if (is_branch)
                    shadow <= SH_W'(BR_SHADOW);
            end
        end
    end

    // Decode-side registers and saturating bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_inst    <= '0;
            id_valid   <= 1'b0;
            id_pc      <= '0;
            bubble_cnt <= '0;
        end else if (!stall_in) begin
            if (issue) begin
                id_inst  <= imem_data;
                id_valid <= 1'b1;
                id_pc    <= pc;
            end else begin
                id_inst  <= '0;
                id_valid <= 1'b0;
                if (bubble_cnt != '1)
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_issue_unit.sv
// Directed bench for hazard_issue_unit with a behavioural instruction memory.
module tb_hazard_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_in = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        br_resolve = 1'b0;
    logic        br_taken = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic [15:0] id_inst;
    logic        id_valid;
    logic [7:0]  id_pc;
    logic [15:0] bubble_cnt;

    logic [15:0] mem [256];
    int checks = 0;
    int errors = 0;

    hazard_issue_unit dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .br_resolve(br_resolve), .br_taken(br_taken), .br_target(br_target),
        .id_inst(id_inst), .id_valid(id_valid), .id_pc(id_pc),
        .bubble_cnt(bubble_cnt)
    );

    assign imem_data = mem[imem_addr];

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case something wedges.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic issued(input string tag, input logic [15:0] inst, input logic [7:0] pc);
        chk({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
        chk({tag, "_inst"}, {16'd0, id_inst}, {16'd0, inst});
        chk({tag, "_pc"}, {24'd0, id_pc}, {24'd0, pc});
    endtask

    task automatic bubble(input string tag, input logic [7:0] pc, input logic [15:0] cnt);
        chk({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
        chk({tag, "_inst"}, {16'd0, id_inst}, 32'd0);
        chk({tag, "_pc"}, {24'd0, id_pc}, {24'd0, pc});
        chk({tag, "_cnt"}, {16'd0, bubble_cnt}, {16'd0, cnt});
    endtask

    initial begin
        // Reset state
        clear_mem();
        #2;
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_inst", {16'd0, id_inst}, 32'd0);
        chk("rst_pc", {24'd0, id_pc}, 32'd0);
        chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("rst_addr", {24'd0, imem_addr}, 32'd0);

        // Independent stream issues back to back
        mem[0] = 16'h2001; mem[1] = 16'h2242; mem[2] = 16'h2483;
        do_reset();
        step(); issued("ind0", 16'h2001, 8'd0);
        step(); issued("ind1", 16'h2242, 8'd1);
        step(); issued("ind2", 16'h2483, 8'd2);
        chk("ind_cnt", {16'd0, bubble_cnt}, 32'd0);

        // RAW: writer r7 then reader r7 -> three bubbles
        clear_mem();
        mem[0] = 16'h01C0; mem[1] = 16'h0007;
        do_reset();
        step(); issued("raw_w", 16'h01C0, 8'd0);
        step(); bubble("raw_b1", 8'd0, 16'd1);
        step(); bubble("raw_b2", 8'd0, 16'd2);
        step(); bubble("raw_b3", 8'd0, 16'd3);
        step(); issued("raw_r", 16'h0007, 8'd1);
        chk("raw_cnt", {16'd0, bubble_cnt}, 32'd3);
        step(); issued("raw_nop", 16'h0000, 8'd2);

        // Same sequence with a 4-cycle stall inside the bubbles
        do_reset();
        step(); issued("stl_w", 16'h01C0, 8'd0);
        step(); bubble("stl_b1", 8'd0, 16'd1);
        stall_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); bubble("stl_hold", 8'd0, 16'd1);
        end
        chk("stl_addr", {24'd0, imem_addr}, 32'd1);
        stall_in = 1'b0;
        step(); bubble("stl_b2", 8'd0, 16'd2);
        step(); bubble("stl_b3", 8'd0, 16'd3);
        step(); issued("stl_r", 16'h0007, 8'd1);

        // Taken branch resolved in the second shadow cycle
        clear_mem();
        mem[0] = 16'h8000; mem[8'h40] = 16'h2001;
        do_reset();
        step(); issued("bt_br", 16'h8000, 8'd0);
        step(); bubble("bt_s1", 8'd0, 16'd1);
        br_resolve = 1'b1; br_taken = 1'b1; br_target = 8'h40;
        step(); bubble("bt_s2", 8'd0, 16'd2);
        br_resolve = 1'b0; br_taken = 1'b0;
        step(); issued("bt_tgt", 16'h2001, 8'h40);

        // Not-taken resolve falls through to branch+1
        do_reset();
        step(); issued("bn_br", 16'h8000, 8'd0);
        step();
        br_resolve = 1'b1; br_taken = 1'b0; br_target = 8'h40;
        step(); bubble("bn_s2", 8'd0, 16'd2);
        br_resolve = 1'b0;
        step(); issued("bn_fall", 16'h0000, 8'd1);

        // Resolve in first shadow cycle is ignored
        do_reset();
        step(); issued("be_br", 16'h8000, 8'd0);
        br_resolve = 1'b1; br_taken = 1'b1; br_target = 8'h40;
        step(); bubble("be_s1", 8'd0, 16'd1);
        br_resolve = 1'b0; br_taken = 1'b0;
        step(); bubble("be_s2", 8'd0, 16'd2);
        step(); issued("be_fall", 16'h0000, 8'd1);

        // Branch after writer: shadow ages the history, no extra RAW bubble
        clear_mem();
        mem[0] = 16'h01C0; mem[1] = 16'h8000; mem[2] = 16'h0007;
        do_reset();
        step(); issued("bw_w", 16'h01C0, 8'd0);
        step(); issued("bw_br", 16'h8000, 8'd1);
        step(); bubble("bw_s1", 8'd1, 16'd1);
        step(); bubble("bw_s2", 8'd1, 16'd2);
        step(); issued("bw_r", 16'h0007, 8'd2);

        // PC wraps 255 -> 0 with NOP fill
        clear_mem();
        mem[255] = 16'h2001;
        do_reset();
        for (int i = 0; i < 256; i++) step();
        issued("wr_255", 16'h2001, 8'd255);
        step(); issued("wr_0", 16'h0000, 8'd0);
        chk("wr_cnt", {16'd0, bubble_cnt}, 32'd0);

        // Reset asserted in a branch shadow
        clear_mem();
        mem[0] = 16'h8000;
        do_reset();
        step(); issued("rb_br", 16'h8000, 8'd0);
        step(); bubble("rb_s1", 8'd0, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rb_valid", {31'd0, id_valid}, 32'd0);
        chk("rb_inst", {16'd0, id_inst}, 32'd0);
        chk("rb_pc", {24'd0, id_pc}, 32'd0);
        chk("rb_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("rb_addr", {24'd0, imem_addr}, 32'd0);
        mem[0] = 16'h2001;
        step();
        rst_n = 1'b1;
        step(); issued("rb_first", 16'h2001, 8'd0);
        chk("rb_first_cnt", {16'd0, bubble_cnt}, 32'd0);
        step(); issued("rb_second", 16'h0000, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_issue_unit.md
Name:
hazard_issue_unit

Overview:
Fetch/issue stage that reads the 256×16 instruction memory through its combinational `add`/`inst` read port and presents one instruction per cycle to decode. It detects the two pipeline hazards at run time: RAW dependencies on recently issued writers, and branch shadows. It inserts bubbles dynamically, so programs need no NOP padding. It also resolves taken branches using a redirect from execute.

Parameters:
- PC_W, 8, instruction address width (256-entry memory)
- RAW_WIN, 3, writer-history depth; equals the number of bubbles after a dependent writer
- BR_SHADOW, 2, bubbles after every branch
- CNT_W, 16, width of the bubble performance counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_in  in  1  downstream hold; unit freezes all state while high
- imem_addr  out  PC_W  address to instruction memory (= pc, combinational from pc register)
- imem_data  in  16  instruction at imem_addr, same cycle
- br_resolve  in  1  execute has resolved the last issued branch
- br_taken  in  1  resolved branch is taken
- br_target  in  PC_W  taken-branch target address
- id_inst  out  16  registered instruction to decode; 16'h0000 on a bubble
- id_valid  out  1  registered; 1 = real instruction, 0 = bubble
- id_pc  out  PC_W  registered address of id_inst (held on bubble)
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
Reset values (async, rst_n=0):
- pc=0, id_inst=0, id_valid=0, id_pc=0, bubble_cnt=0
- scoreboard entries invalid, shadow counter 0

Decode of imem_data (op = [15:13]):
- op 000: writes rd=[8:6]; reads [2:0] and [5:3].
- op 001 and op 010: write rd=[2:0]; read [5:3].
- All other ops: no write, no reads.
- 16'h0000 is a NOP: no write, no reads (overrides op 000).
- All 8 register numbers participate in matching, including r0.

Scoreboard:
- RAW_WIN-entry shift register of {valid, rd}.
- Shifts on every cycle with stall_in=0; entry 0 receives the rd of the instruction issued that cycle, or invalid on a bubble.
- Hazard = any valid entry whose rd equals any read field of imem_data.

Per cycle with stall_in=0, in priority order:
1. Shadow counter > 0: bubble; pc holds; counter decrements.
   - On the cycle the counter is 1: if br_resolve&&br_taken, pc<=br_target; otherwise pc holds (already branch+1).
   - br_resolve in any other cycle is ignored.
2. Hazard: bubble; pc holds.
3. Otherwise issue: id_inst<=imem_data, id_valid<=1, id_pc<=pc, pc<=pc+1.
   - pc wraps 255→0.
   - If op==100, shadow counter<=BR_SHADOW.

Bubble outputs and counter:
- Bubble drives id_inst<=0, id_valid<=0 and increments bubble_cnt, saturating at all-ones.

Timing:
- A writer issued at edge t blocks a dependent instruction at edges t+1..t+3; the dependent issues at t+4 (exactly 3 bubbles).
- An independent instruction issues at t+1.

Stall and reset:
- stall_in=1 holds pc, scoreboard, shadow, bubble_cnt and all id_* outputs; br_resolve is ignored that cycle.
- Reset mid-operation discards shadow and scoreboard; fetch restarts at address 0 on the first edge after release.
- Branch back-to-back with a writer: the shadow bubbles also age the scoreboard, so a later dependent needs only the remaining RAW bubbles.
- A branch whose successor depends on an earlier writer gets its shadow bubbles first, then any remaining hazard bubbles.

Test Plan:
- Reset, then memory = independent instructions 0x2001, 0x2242, 0x2483 at 0..2 → id_valid=1 on three consecutive edges; id_pc=0,1,2; bubble_cnt=0.
- mem[0]=0x01C0 (op000, rd=7), mem[1]=0x0007 (reads r7) → id_inst=0x01C0, then 3 bubbles (id_inst=0, id_valid=0), then 0x0007 with id_pc=1; bubble_cnt=3.
- mem[0]=0x8000 (branch); br_resolve=1, br_taken=1, br_target=0x40 in the second shadow cycle → 2 bubbles, next issued id_pc=0x40. Repeat with br_taken=0 → next id_pc=1. br_resolve pulsed in the first shadow cycle only → ignored; next id_pc=1.
- stall_in held 4 cycles during the RAW bubble sequence → outputs and bubble_cnt frozen; sequence resumes with identical remaining bubble count.
- Fill 0..255 with NOPs except mem[255]=0x2001 → after id_pc=255, next id_pc=0; no bubbles.
- Assert rst_n=0 during a branch shadow → all outputs 0 immediately; after release, first issue is id_pc=0 with no residual bubbles.
